// File: rtl/apb_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter_if
// Description : Requester-side and APB-monitor signal bundle for apb_req_arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic                          m_start;
    logic                          m_wr;
    logic [ADDR_WIDTH-1:0]         m_address;
    logic [DATA_WIDTH-1:0]         m_wdata;
    logic                          apb_psel;
    logic                          apb_penable;
    logic                          apb_pready;
    logic                          apb_pslverr;
    logic [DATA_WIDTH-1:0]         apb_prdata;

    // Arbiter side
    modport slave (
        input  req, req_wr, req_addr, req_wdata,
        input  apb_psel, apb_penable, apb_pready, apb_pslverr, apb_prdata,
        output gnt, done, rsp_rdata, rsp_err,
        output m_start, m_wr, m_address, m_wdata
    );

    // Requesters and bus environment side
    modport master (
        output req, req_wr, req_addr, req_wdata,
        output apb_psel, apb_penable, apb_pready, apb_pslverr, apb_prdata,
        input  gnt, done, rsp_rdata, rsp_err,
        input  m_start, m_wr, m_address, m_wdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter
// Description : Round-robin sharing of one APB master command port between
//               NUM_REQ requesters. Optional watchdog: define ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input wire              clk,
    input wire              rst,
    apb_req_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_BUSY = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("apb_req_arbiter: parameter out of range");
    end

    state_t                 r_state, w_state_nxt;
    logic [NUM_REQ-1:0]     r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]     r_done, w_done_nxt;
    logic [DATA_WIDTH-1:0]  r_rdata, w_rdata_nxt;
    logic                   r_rsp_err, w_rsp_err_nxt;
    logic                   r_start, w_start_nxt;
    logic                   r_wr, w_wr_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0]  r_wdata, w_wdata_nxt;
    logic [IDX_W-1:0]       r_rr_ptr, w_rr_nxt;
    logic [IDX_W-1:0]       r_gidx, w_gidx_nxt;
    logic [IDX_W-1:0]       w_win;
    logic                   w_complete;
    logic                   w_timeout;

    logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  w_wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_addr_arr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Descending scan so the candidate closest after r_rr_ptr is written last.
    always_comb begin
        w_win = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ)]) begin
                w_win = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_complete = bus.apb_psel & bus.apb_penable & bus.apb_pready;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] r_wait;

    // REQ is only entered from IDLE, so clearing in IDLE clears on REQ entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (r_state == ST_IDLE) begin
            r_wait <= '0;
        end else if (r_state == ST_REQ || r_state == ST_BUSY) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_REQ || r_state == ST_BUSY) &&
                       (r_wait == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_done_nxt    = '0;
        w_rdata_nxt   = r_rdata;
        w_rsp_err_nxt = 1'b0;
        w_start_nxt   = r_start;
        w_wr_nxt      = r_wr;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_rr_nxt      = r_rr_ptr;
        w_gidx_nxt    = r_gidx;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                    w_gidx_nxt  = w_win;
                    w_wr_nxt    = bus.req_wr[w_win];
                    w_addr_nxt  = w_addr_arr[w_win];
                    w_wdata_nxt = w_wdata_arr[w_win];
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_timeout) begin
                    w_start_nxt   = 1'b0;
                    w_done_nxt    = r_gnt;
                    w_rsp_err_nxt = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else if (bus.apb_psel) begin
                    w_start_nxt = 1'b0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_complete) begin
                    if (!r_wr) begin
                        w_rdata_nxt = bus.apb_prdata;
                    end
                    w_done_nxt    = r_gnt;
                    w_rsp_err_nxt = bus.apb_pslverr;
                    w_state_nxt   = ST_DONE;
                end else if (w_timeout) begin
                    w_done_nxt    = r_gnt;
                    w_rsp_err_nxt = 1'b1;
                    w_state_nxt   = ST_DONE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_rr_nxt    = r_gidx;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_rsp_err <= 1'b0;
            r_start   <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rr_ptr  <= IDX_W'(NUM_REQ - 1);
            r_gidx    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rsp_err <= w_rsp_err_nxt;
            r_start   <= w_start_nxt;
            r_wr      <= w_wr_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_gidx    <= w_gidx_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.m_start   = r_start;
    assign bus.m_wr      = r_wr;
    assign bus.m_address = r_addr;
    assign bus.m_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_req_arbiter
// Description : Scoreboard bench for apb_req_arbiter with a simple APB slave
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_req_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_req_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [NR-1:0] gnt;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        logic [NR-1:0] done;
        logic [DW-1:0] rdata;
        logic          err;
    } done_t;

    gnt_t  exp_gnt_q[$];
    done_t exp_done_q[$];

    int n_checks = 0;
    int n_errors = 0;

    int slave_wait = 0;
    bit slave_err  = 1'b0;
    bit slave_hang = 1'b0;
    int sst        = 0;
    int wcnt       = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : ~a;
    endfunction

    task automatic slave_idle();
        sst = 0;
        wcnt = 0;
        bus.apb_psel    = 1'b0;
        bus.apb_penable = 1'b0;
        bus.apb_pready  = 1'b0;
        bus.apb_pslverr = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_wr[i]               = wr;
        bus.req_addr[i*AW +: AW]    = a;
        bus.req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic push_gnt(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_t g;
        g.gnt = NR'(1) << i; g.wr = wr; g.addr = a; g.wdata = d;
        exp_gnt_q.push_back(g);
    endtask

    task automatic push_done(input int i, input logic [DW-1:0] rd, input logic err);
        done_t e;
        e.done = NR'(1) << i; e.rdata = rd; e.err = err;
        exp_done_q.push_back(e);
    endtask

    // Returns on the negedge where the n-th done pulse is visible.
    task automatic wait_done(input int n, input string name);
        int seen = 0;
        for (int c = 0; c < 300 && seen < n; c++) begin
            @(negedge clk);
            if (bus.done != '0) seen++;
        end
        if (seen < n) begin
            n_checks++; n_errors++;
            $display("FAIL %s: done pulses got %0d expected %0d", name, seen, n);
        end
    endtask

    task automatic wait_access(input string name);
        int c = 0;
        while (!(bus.apb_psel && bus.apb_penable) && c < 100) begin
            @(negedge clk); c++;
        end
        if (c >= 100) begin
            n_checks++; n_errors++;
            $display("FAIL %s: access phase got none expected one", name);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        slave_idle();
        repeat (2) @(negedge clk);
        slave_idle();
        rst = 1'b0;
    endtask

    // APB slave model: psel on seeing m_start, then access with slave_wait wait states.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                slave_idle();
            end else begin
                case (sst)
                    0: if (bus.m_start) begin
                        bus.apb_psel = 1'b1;
                        sst = 1;
                    end
                    1: begin
                        bus.apb_penable = 1'b1;
                        wcnt = slave_wait;
                        bus.apb_prdata  = rdata_of(bus.m_address);
                        bus.apb_pslverr = slave_err;
                        bus.apb_pready  = (wcnt == 0) && !slave_hang;
                        sst = 2;
                    end
                    default: begin
                        if (bus.apb_pready) begin
                            slave_idle();
                        end else begin
                            if (wcnt > 0) wcnt--;
                            bus.apb_pready = (wcnt == 0) && !slave_hang;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pops expectations on each new grant and each done pulse.
    initial begin
        logic [NR-1:0] prev_gnt;
        gnt_t  eg;
        done_t ed;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.gnt != '0 && prev_gnt == '0) begin
                    if (exp_gnt_q.size() == 0) begin
                        check("grant_unexpected", 128'(bus.gnt), 128'(0));
                    end else begin
                        eg = exp_gnt_q.pop_front();
                        check("grant", {bus.gnt, bus.m_start, bus.m_wr, bus.m_address, bus.m_wdata},
                              {eg.gnt, 1'b1, eg.wr, eg.addr, eg.wdata});
                    end
                end
                if (bus.done != '0) begin
                    if (exp_done_q.size() == 0) begin
                        check("done_unexpected", 128'(bus.done), 128'(0));
                    end else begin
                        ed = exp_done_q.pop_front();
                        check("done", {bus.done, bus.rsp_rdata, bus.rsp_err},
                              {ed.done, ed.rdata, ed.err});
                    end
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int k;
        rst = 1'b1;
        bus.req = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.apb_prdata = '0;
        slave_idle();
        repeat (2) @(negedge clk);

        check("rst_gnt",     128'(bus.gnt),       128'(0));
        check("rst_done",    128'(bus.done),      128'(0));
        check("rst_rdata",   128'(bus.rsp_rdata), 128'(0));
        check("rst_err",     128'(bus.rsp_err),   128'(0));
        check("rst_start",   128'(bus.m_start),   128'(0));
        check("rst_wr",      128'(bus.m_wr),      128'(0));
        check("rst_addr",    128'(bus.m_address), 128'(0));
        check("rst_wdata",   128'(bus.m_wdata),   128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single read from requester 0
        set_lane(0, 1'b0, 32'h10, 32'h1111_0000);
        push_gnt(0, 1'b0, 32'h10, 32'h1111_0000);
        push_done(0, 32'hDEAD_BEEF, 1'b0);
        bus.req = 4'b0001;
        @(negedge clk);
        check("grant_latency", 128'(bus.gnt), 128'(4'b0001));
        wait_done(1, "single_read");
        bus.req = '0;
        @(negedge clk);

        // Slave error on a write; read data must stay at the previous value
        slave_err = 1'b1;
        set_lane(1, 1'b1, 32'h20, 32'h2222_0000);
        push_gnt(1, 1'b1, 32'h20, 32'h2222_0000);
        push_done(1, 32'hDEAD_BEEF, 1'b1);
        bus.req = 4'b0010;
        wait_done(1, "slave_err");
        bus.req = '0;
        slave_err = 1'b0;
        @(negedge clk);

        // Late request from requester 2 while requester 0 is busy
        slave_wait = 3;
        set_lane(0, 1'b0, 32'h30, 32'h3333_0000);
        set_lane(2, 1'b0, 32'h40, 32'h4444_0000);
        push_gnt(0, 1'b0, 32'h30, 32'h3333_0000);
        push_done(0, 32'hFFFF_FFCF, 1'b0);
        push_gnt(2, 1'b0, 32'h40, 32'h4444_0000);
        push_done(2, 32'hFFFF_FFBF, 1'b0);
        bus.req = 4'b0001;
        wait_access("late_access");
        bus.req = 4'b0101;
        bad = 0;
        k = 0;
        while (bus.done == '0 && k < 100) begin
            if (bus.gnt != 4'b0001) bad++;
            @(negedge clk); k++;
        end
        check("late_hold", 128'(bad), 128'(0));
        bus.req = 4'b0100;
        @(negedge clk);
        check("grant_gap", 128'(bus.gnt), 128'(0));
        @(negedge clk);
        check("late_grant", 128'(bus.gnt), 128'(4'b0100));
        wait_done(1, "late_done");
        bus.req = '0;
        slave_wait = 0;
        @(negedge clk);

        // Round-robin after reset: all requesters writing continuously
        do_reset();
        for (int i = 0; i < NR; i++) set_lane(i, 1'b1, AW'(4 * i), DW'(32'hA0 + i));
        for (int n = 0; n < 5; n++) begin
            push_gnt(n % NR, 1'b1, AW'(4 * (n % NR)), DW'(32'hA0 + (n % NR)));
            push_done(n % NR, 32'h0, 1'b0);
        end
        bus.req = 4'b1111;
        wait_done(5, "round_robin");
        bus.req = '0;
        @(negedge clk);

        // Reset while requester 1 is in BUSY
        slave_wait = 5;
        set_lane(1, 1'b0, 32'h50, 32'h5555_0000);
        push_gnt(1, 1'b0, 32'h50, 32'h5555_0000);
        bus.req = 4'b0010;
        wait_access("rst_busy_access");
        rst = 1'b1;
        bus.req = '0;
        slave_idle();
        @(negedge clk);
        check("rstbusy_gnt",   128'(bus.gnt),     128'(0));
        check("rstbusy_done",  128'(bus.done),    128'(0));
        check("rstbusy_start", 128'(bus.m_start), 128'(0));
        slave_idle();
        rst = 1'b0;
        slave_wait = 0;
        for (int i = 0; i < NR; i++) set_lane(i, 1'b0, AW'(32'h60 + 4 * i), DW'(32'hB0 + i));
        push_gnt(0, 1'b0, 32'h60, 32'hB0);
        push_done(0, 32'hFFFF_FF9F, 1'b0);
        bus.req = 4'b1111;
        wait_done(1, "after_reset");
        bus.req = '0;
        @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: slave never ready; requester 1 times out, requester 0 follows
        slave_hang = 1'b1;
        set_lane(0, 1'b0, 32'h70, 32'h7777_0000);
        set_lane(1, 1'b0, 32'h74, 32'h7474_0000);
        push_gnt(1, 1'b0, 32'h74, 32'h7474_0000);
        push_done(1, 32'hFFFF_FF9F, 1'b1);
        push_gnt(0, 1'b0, 32'h70, 32'h7777_0000);
        push_done(0, 32'hFFFF_FF8F, 1'b0);
        bus.req = 4'b0011;
        k = 0;
        while (bus.gnt == '0 && k < 20) begin
            @(negedge clk); k++;
        end
        k = 0;
        while (bus.done == '0 && k < 40) begin
            @(negedge clk); k++;
        end
        check("timeout_latency", 128'(k), 128'(8));
        bus.req = 4'b0001;
        slave_hang = 1'b0;
        slave_idle();
        wait_done(1, "after_timeout");
        bus.req = '0;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("gnt_queue_empty",  128'(exp_gnt_q.size()),  128'(0));
        check("done_queue_empty", 128'(exp_done_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
